// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache bus arbiter: FSM states, owner encoding, burst sizing.
package cache_arb_pkg;

    localparam int unsigned DEF_BURST_LEN = 8;
    localparam int unsigned BEAT_W        = $clog2(DEF_BURST_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StDcWr,
        StDcRd,
        StIcRd
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnDcWr,
        OwnDcRd,
        OwnIc
    } arb_owner_e;

    function automatic arb_owner_e state_owner(input arb_state_e st);
        arb_owner_e own;
        unique case (st)
            StDcWr:  own = OwnDcWr;
            StDcRd:  own = OwnDcRd;
            StIcRd:  own = OwnIc;
            default: own = OwnNone;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/cache_arb_addr_gen.sv
// Per-beat address generation: line base plus word offset, with optional critical-word-first
// wrap when CACHE_ARB_CWF_EN is defined.
module cache_arb_addr_gen
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [$clog2(BURST_LEN)-1:0] cnt_i,
    input  logic                         rd_burst_i,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [$clog2(BURST_LEN)-1:0] beat_idx_o
);

    localparam int unsigned BeatW = $clog2(BURST_LEN);

    logic [BeatW-1:0] word_off;

`ifdef CACHE_ARB_CWF_EN
    logic unused_bits;
    assign unused_bits = ^base_addr_i[1:0];

    // Offset is BeatW bits wide, so the sum wraps within the line by construction.
    always_comb begin
        word_off = cnt_i;
        if (rd_burst_i) begin
            word_off = base_addr_i[BeatW+1:2] + cnt_i;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{rd_burst_i, base_addr_i[BeatW+1:0]};

    always_comb begin
        word_off = cnt_i;
    end
`endif

    assign mem_addr_o = {base_addr_i[ADDR_W-1:BeatW+2], word_off, 2'b00};
    assign beat_idx_o = word_off;

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates the external memory port between I-cache refill, D-cache refill and D-cache
// write-back, running fixed-length line bursts. Optional CWF via CACHE_ARB_CWF_EN.
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ic_rd_req,
    input  logic [ADDR_W-1:0]            ic_rd_addr,
    output logic                         ic_rvalid,
    output logic                         ic_done,
    input  logic                         dc_rd_req,
    input  logic [ADDR_W-1:0]            dc_rd_addr,
    output logic                         dc_rvalid,
    output logic                         dc_rd_done,
    input  logic                         dc_wr_req,
    input  logic [ADDR_W-1:0]            dc_wr_addr,
    input  logic [DATA_W-1:0]            dc_wdata,
    output logic                         dc_wready,
    output logic                         dc_wr_done,
    output logic [$clog2(BURST_LEN)-1:0] beat_idx,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         arb_busy
);

    localparam int unsigned  BeatW    = $clog2(BURST_LEN);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    arb_state_e        state_q, state_d;
    logic [BeatW-1:0]  cnt_q, cnt_d;
    logic              last_ic_q, last_ic_d;
    logic [ADDR_W-1:0] base_q, base_d;

    arb_owner_e        owner;
    logic              busy;
    logic              last_ack;
    logic [ADDR_W-1:0] gen_addr;
    logic [BeatW-1:0]  gen_beat;

    // Read data goes straight from the bridge to the caches.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_ic_q <= 1'b0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_ic_q <= last_ic_d;
            base_q    <= base_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_ic_d = last_ic_q;
        base_d    = base_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Write-back first so a victim leaves before its set is refilled.
                if (dc_wr_req) begin
                    state_d = StDcWr;
                    base_d  = dc_wr_addr;
                end else if (ic_rd_req && (!dc_rd_req || !last_ic_q)) begin
                    state_d   = StIcRd;
                    base_d    = ic_rd_addr;
                    last_ic_d = 1'b1;
                end else if (dc_rd_req) begin
                    state_d   = StDcRd;
                    base_d    = dc_rd_addr;
                    last_ic_d = 1'b0;
                end
            end
            default: begin
                if (mem_ack) begin
                    if (cnt_q == LastBeat) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    cache_arb_addr_gen #(
        .ADDR_W   (ADDR_W),
        .BURST_LEN(BURST_LEN)
    ) u_addr_gen (
        .base_addr_i(base_q),
        .cnt_i      (cnt_q),
        .rd_burst_i (state_q != StDcWr),
        .mem_addr_o (gen_addr),
        .beat_idx_o (gen_beat)
    );

    always_comb begin
        owner      = state_owner(state_q);
        busy       = (state_q != StIdle);
        last_ack   = mem_ack && (cnt_q == LastBeat);
        arb_busy   = busy;
        mem_req    = busy;
        mem_we     = 1'b0;
        mem_addr   = '0;
        beat_idx   = '0;
        mem_wdata  = '0;
        ic_rvalid  = 1'b0;
        ic_done    = 1'b0;
        dc_rvalid  = 1'b0;
        dc_rd_done = 1'b0;
        dc_wready  = 1'b0;
        dc_wr_done = 1'b0;
        if (busy) begin
            mem_addr = gen_addr;
            beat_idx = gen_beat;
        end
        unique case (owner)
            OwnDcWr: begin
                mem_we     = 1'b1;
                mem_wdata  = dc_wdata;
                dc_wready  = mem_ack;
                dc_wr_done = last_ack;
            end
            OwnDcRd: begin
                dc_rvalid  = mem_ack;
                dc_rd_done = last_ack;
            end
            OwnIc: begin
                ic_rvalid = mem_ack;
                ic_done   = last_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter; expectations follow CACHE_ARB_CWF_EN.
module tb_cache_bus_arbiter;

    localparam int BL      = 8;
    localparam int OwnIc   = 1;
    localparam int OwnDcRd = 2;
    localparam int OwnDcWr = 3;
`ifdef CACHE_ARB_CWF_EN
    localparam bit Cwf = 1'b1;
`else
    localparam bit Cwf = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ic_rd_req, dc_rd_req, dc_wr_req;
    logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_rd_done, dc_wready, dc_wr_done;
    logic [31:0] dc_wdata;
    logic [2:0]  beat_idx;
    logic        mem_req, mem_we, mem_ack, arb_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp;
    int n_err;

    cache_bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .BURST_LEN(BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_rd_req (ic_rd_req),
        .ic_rd_addr(ic_rd_addr),
        .ic_rvalid (ic_rvalid),
        .ic_done   (ic_done),
        .dc_rd_req (dc_rd_req),
        .dc_rd_addr(dc_rd_addr),
        .dc_rvalid (dc_rvalid),
        .dc_rd_done(dc_rd_done),
        .dc_wr_req (dc_wr_req),
        .dc_wr_addr(dc_wr_addr),
        .dc_wdata  (dc_wdata),
        .dc_wready (dc_wready),
        .dc_wr_done(dc_wr_done),
        .beat_idx  (beat_idx),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // D-cache model: victim word selected combinationally by beat_idx.
    always_comb dc_wdata = 32'hD0D0_0000 | {29'd0, beat_idx};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle in IDLE: present requests (all at addr) and confirm the port is quiet.
    task automatic idle_cycle(input string tag, input logic ic, input logic dr, input logic dw,
                              input logic [31:0] addr);
        @(negedge clk);
        ic_rd_req  = ic;
        dc_rd_req  = dr;
        dc_wr_req  = dw;
        ic_rd_addr = addr;
        dc_rd_addr = addr;
        dc_wr_addr = addr;
        mem_ack    = 1'b0;
        #1;
        check_val({tag, ":idle_req"}, mem_req, 0);
        check_val({tag, ":idle_busy"}, arb_busy, 0);
        check_val({tag, ":idle_dones"}, {ic_done, dc_rd_done, dc_wr_done}, 0);
    endtask

    // Run n_beats acked beats of a burst, acking every period-th cycle; addresses are scrambled
    // during the burst to show they are captured only at grant.
    task automatic run_burst(input string tag, input int owner, input logic [31:0] req_addr,
                             input int n_beats, input int period, output int cycles);
        int          k;
        int          w;
        int          rw;
        logic        ack;
        logic [31:0] exp_addr;
        k      = 0;
        cycles = 0;
        rw     = int'((req_addr >> 2) & 32'h7);
        while (k < n_beats && cycles < 200) begin
            @(negedge clk);
            ack        = ((cycles % period) == period - 1);
            mem_ack    = ack;
            mem_rdata  = $urandom;
            ic_rd_addr = $urandom;
            dc_rd_addr = $urandom;
            dc_wr_addr = $urandom;
            #1;
            w        = (Cwf && owner != OwnDcWr) ? ((rw + k) % BL) : k;
            exp_addr = (req_addr & ~32'h1F) | 32'(w * 4);
            check_val({tag, ":mem_req"}, mem_req, 1);
            check_val({tag, ":busy"}, arb_busy, 1);
            check_val({tag, ":mem_we"}, mem_we, owner == OwnDcWr);
            check_val({tag, ":mem_addr"}, mem_addr, exp_addr);
            check_val({tag, ":beat_idx"}, beat_idx, w);
            check_val({tag, ":mem_wdata"}, mem_wdata,
                      (owner == OwnDcWr) ? (32'hD0D0_0000 | 32'(w)) : 32'h0);
            check_val({tag, ":ic_rvalid"}, ic_rvalid, ack && owner == OwnIc);
            check_val({tag, ":dc_rvalid"}, dc_rvalid, ack && owner == OwnDcRd);
            check_val({tag, ":dc_wready"}, dc_wready, ack && owner == OwnDcWr);
            check_val({tag, ":ic_done"}, ic_done, ack && k == BL - 1 && owner == OwnIc);
            check_val({tag, ":dc_rd_done"}, dc_rd_done, ack && k == BL - 1 && owner == OwnDcRd);
            check_val({tag, ":dc_wr_done"}, dc_wr_done, ack && k == BL - 1 && owner == OwnDcWr);
            if (ack) k++;
            cycles++;
        end
        check_val({tag, ":beats"}, k, n_beats);
    endtask

    initial begin
        int cyc;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        ic_rd_req  = 1'b0;
        dc_rd_req  = 1'b0;
        dc_wr_req  = 1'b0;
        ic_rd_addr = '0;
        dc_rd_addr = '0;
        dc_wr_addr = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst:mem_req", mem_req, 0);
        check_val("rst:busy", arb_busy, 0);
        check_val("rst:mem_addr", mem_addr, 0);
        check_val("rst:beat_idx", beat_idx, 0);
        check_val("rst:we_wdata", {mem_we, mem_wdata}, 0);
        check_val("rst:strobes",
                  {ic_rvalid, ic_done, dc_rvalid, dc_rd_done, dc_wready, dc_wr_done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // All three at once: write-back, then I-cache (first tie), then D-cache refill.
        idle_cycle("t1a", 1, 1, 1, 32'h1000_0040);
        run_burst("t1_wr", OwnDcWr, 32'h1000_0040, BL, 1, cyc);
        check_val("t1_wr:cycles", cyc, 8);
        idle_cycle("t1b", 1, 1, 0, 32'h1000_0040);
        run_burst("t1_ic", OwnIc, 32'h1000_0040, BL, 1, cyc);
        idle_cycle("t1c", 0, 1, 0, 32'h1000_0040);
        run_burst("t1_dc", OwnDcRd, 32'h1000_0040, BL, 1, cyc);

        // Fairness: both read requests held; last served was D-cache.
        idle_cycle("t2a", 1, 1, 0, 32'h3000_0080);
        run_burst("t2_ic0", OwnIc, 32'h3000_0080, BL, 1, cyc);
        idle_cycle("t2b", 1, 1, 0, 32'h3000_00A0);
        run_burst("t2_dc0", OwnDcRd, 32'h3000_00A0, BL, 1, cyc);
        idle_cycle("t2c", 1, 1, 0, 32'h3000_00C0);
        run_burst("t2_ic1", OwnIc, 32'h3000_00C0, BL, 1, cyc);
        idle_cycle("t2d", 1, 1, 0, 32'h3000_00E0);
        run_burst("t2_dc1", OwnDcRd, 32'h3000_00E0, BL, 1, cyc);

        // Wait states on a read, then on a write-back from a mid-line address.
        idle_cycle("t3a", 0, 1, 0, 32'h4000_0060);
        run_burst("t3_rd", OwnDcRd, 32'h4000_0060, BL, 3, cyc);
        check_val("t3_rd:cycles", cyc, 24);
        idle_cycle("t3b", 0, 0, 1, 32'h2000_0054);
        run_burst("t3_wr", OwnDcWr, 32'h2000_0054, BL, 2, cyc);
        check_val("t3_wr:cycles", cyc, 16);

        // I-cache miss mid-line: wrap order under CWF, aligned order otherwise.
        idle_cycle("t4a", 1, 0, 0, 32'h0000_0114);
        run_burst("t4_ic", OwnIc, 32'h0000_0114, BL, 1, cyc);

        // Reset after four beats of a D-cache refill aborts it.
        idle_cycle("t5a", 0, 1, 0, 32'h5000_0020);
        run_burst("t5_part", OwnDcRd, 32'h5000_0020, 4, 1, cyc);
        @(negedge clk);
        mem_ack = 1'b1;
        rst     = 1'b1;
        #1;
        check_val("t5:mem_req", mem_req, 0);
        check_val("t5:busy", arb_busy, 0);
        check_val("t5:dc_rd_done", dc_rd_done, 0);
        check_val("t5:dc_rvalid", dc_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle("t5b", 0, 1, 0, 32'h5000_0020);
        run_burst("t5_full", OwnDcRd, 32'h5000_0020, BL, 1, cyc);
        idle_cycle("end", 0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares the single external memory port between I-cache refills, D-cache refills and D-cache dirty-line write-backs. It grants one requester at a time and runs a fixed-length line burst to completion. It also generates per-beat addresses and returns per-beat handshakes to the owning cache. It sits between the two caches and the memory/bridge interface. The caches keep raising their stall requests to the pipeline controller until this block pulses their `done`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, beat width (one word)
- `BURST_LEN`, 8, words per cache line; power of two, 2..16

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ic_rd_req`  in  1  I-cache refill request, held high until `ic_done`
- `ic_rd_addr`  in  ADDR_W  I-cache miss address
- `ic_rvalid`  out  1  beat `beat_idx` of `mem_rdata` is valid for I-cache
- `ic_done`  out  1  one-cycle pulse when the last I-cache beat is accepted
- `dc_rd_req`, `dc_rd_addr`, `dc_rvalid`, `dc_rd_done`  same as the I-cache set, for D-cache refill
- `dc_wr_req`  in  1  D-cache write-back request, held until `dc_wr_done`
- `dc_wr_addr`  in  ADDR_W  victim line address
- `dc_wdata`  in  DATA_W  victim word selected by `beat_idx`; combinational from D-cache
- `dc_wready`  out  1  current write beat accepted; D-cache may advance
- `dc_wr_done`  out  1  one-cycle pulse on the last write beat
- `beat_idx`  out  log2(BURST_LEN)  word index within the line for the current beat
- `mem_req`  out  1  beat request to memory
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  ADDR_W  word-aligned beat address
- `mem_wdata`  out  DATA_W  equals `dc_wdata` in write state, else 0
- `mem_ack`  in  1  beat complete this cycle
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `arb_busy`  out  1  state is not IDLE

## Operation
- FSM states: IDLE, DC_WR, DC_RD, IC_RD.
- Requests are sampled only in IDLE.
- Grant priority from IDLE: `dc_wr_req` always wins, because a write-back must precede the refill of the same set.
- Between `dc_rd_req` and `ic_rd_req`, a 1-bit `last_ic` flag decides the grant. When both are pending, the one not served last is granted.
- `last_ic` resets to 0, so the first tie goes to I-cache.
- The beat counter `cnt` resets to 0 on entry to any burst state and increments on every `mem_ack`.
- The base address is the granted request address, captured into a register at grant. Its low log2(BURST_LEN)+2 bits are used per the Configuration section.
- `mem_addr` = {line_base, word_offset, 2'b00}.
- In a burst state, `mem_req`=1. `mem_we`=1 only in DC_WR.
- The `rvalid` of the owner, or `dc_wready`, equals `mem_ack`.
- The owner's `done` = `mem_ack` && `cnt`==BURST_LEN-1. On the next edge the FSM returns to IDLE.
- Deasserting a request mid-burst is a protocol error. The burst still completes and `done` still pulses.
- Request addresses are sampled only at grant; later changes are ignored.

## Timing
- Reset values: state IDLE, `cnt`=0, `last_ic`=0, captured address 0. All outputs are 0.
- Reset asserted mid-burst aborts the burst. `mem_req` falls asynchronously and no `done` pulse is issued.
- Grant latency: a request high at edge N in IDLE means the state changes at edge N and `mem_req` is high in cycle N+1.
- Back-to-back beats: `mem_ack` may be high every cycle, giving BURST_LEN cycles minimum per burst.
- Wait states: `mem_req`, `mem_addr` and `mem_wdata` hold stable until `mem_ack`.
- Exactly one IDLE cycle follows every burst, so the minimum gap between bursts is 1 cycle.
- Outputs `rvalid`, `wready` and `done` are combinational from `mem_ack` and state, with zero latency.

## Configuration
- `CACHE_ARB_CWF_EN` defined: critical-word-first. The first beat is the requested word, and `word_offset` = (req_word + `cnt`) mod BURST_LEN, wrapping within the line. `beat_idx` = `word_offset`. Applies to reads only; write-backs always start at word 0.
- Undefined: all bursts start at word 0 of the aligned line, and `beat_idx` = `cnt`.

## Structure
- Shared package `cache_arb_pkg` holds:
  - the state enum (IDLE, DC_WR, DC_RD, IC_RD)
  - `BURST_LEN` default
  - the `BEAT_W` = $clog2(BURST_LEN) constant
  - the owner encoding
- One sub-module, `cache_arb_addr_gen`: combinational line-base/offset math including the CWF wrap. It is instantiated once.
- FSM, counter and fairness flag live in the top.

## Test plan
- Simultaneous `dc_wr_req`, `dc_rd_req`, `ic_rd_req` at 0x1000_0040, with `mem_ack` every cycle. Required: DC_WR 8 beats at 0x40..0x5C with `mem_we`=1, then 1 IDLE cycle, then IC_RD (tie goes to I-cache), then IDLE, then DC_RD. Each `done` pulses exactly once.
- Fairness: `ic_rd_req` and `dc_rd_req` held continuously. Required: grants alternate IC, DC, IC, DC over 4 bursts.
- Wait states: `mem_ack` every 3rd cycle. Required: `mem_addr` and `mem_wdata` stable during waits, 24-cycle burst, `rvalid` count = 8.
- With `CACHE_ARB_CWF_EN`, I-cache miss at 0x0000_0114. Required: `beat_idx` 5,6,7,0,1,2,3,4 and `mem_addr` 0x114,0x118,0x11C,0x100,…,0x110. Without the macro: 0x100..0x11C in order.
- `rst` asserted after beat 3 of DC_RD. Required: `mem_req`=0 immediately, no `dc_rd_done`, then after release a fresh request starts at beat 0.
